// File: rtl/mux4_arbiter_if.sv
// Requester/consumer bus of the 4:1 round-robin arbiter.
// master: arbiter side; slave: requesters plus downstream consumer.
interface mux4_arbiter_if #(parameter int WIDTH = 32);
  logic [3:0]       req;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic             y_ready;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic [1:0]       sel;
  logic [3:0]       grant;
  logic [3:0]       ack;

  modport master (
    input  req, d0, d1, d2, d3, y_ready,
    output y, y_valid, sel, grant, ack
  );
  modport slave (
    output req, d0, d1, d2, d3, y_ready,
    input  y, y_valid, sel, grant, ack
  );
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter driving a 4:1 select into a registered valid/ready output.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest, no rotating pointer).
module mux4_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          clrn,
  mux4_arbiter_if.master bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic             hs;
  logic [3:0]       mreq;
  logic [1:0]       base;
  logic [1:0]       w;
  logic             found;
  logic [WIDTH-1:0] dmux;

  assign hs      = bus.y_valid & bus.y_ready;
  assign bus.ack = hs ? (4'b0001 << bus.sel) : 4'b0000;
  // The word being consumed this cycle must not win the re-arbitration.
  assign mreq    = bus.req & ~bus.ack;

`ifdef ARB_FIXED_PRIO_EN
  assign base = 2'd0;
`else
  logic [1:0] ptr;
  assign base = ptr;
`endif

  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    w     = 2'd0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = base + 2'(i);
      if (!found && mreq[idx]) begin
        found = 1'b1;
        w     = idx;
      end
    end
  end

  always_comb begin
    case (w)
      2'd0:    dmux = bus.d0;
      2'd1:    dmux = bus.d1;
      2'd2:    dmux = bus.d2;
      default: dmux = bus.d3;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
      ptr         <= 2'd0;
`endif
      bus.y       <= '0;
      bus.y_valid <= 1'b0;
      bus.sel     <= 2'd0;
      bus.grant   <= 4'b0000;
    end else if ((state == IDLE) || hs) begin
      if (found) begin
        state       <= BUSY;
`ifndef ARB_FIXED_PRIO_EN
        ptr         <= w + 2'd1;
`endif
        bus.y       <= dmux;
        bus.y_valid <= 1'b1;
        bus.sel     <= w;
        bus.grant   <= 4'b0001 << w;
      end else begin
        state       <= IDLE;
        bus.y_valid <= 1'b0;
        bus.grant   <= 4'b0000;
      end
    end
  end
endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter with an ordered scoreboard of expected handshakes.
module tb_mux4_arbiter;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [1:0]       idx;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk, clrn;
  logic [WIDTH-1:0] dv [4];
  exp_t exp_q [$];
  int ncmp = 0;
  int nerr = 0;

  mux4_arbiter_if #(.WIDTH(WIDTH)) bif ();

  assign bif.d0 = dv[0];
  assign bif.d1 = dv[1];
  assign bif.d2 = dv[2];
  assign bif.d3 = dv[3];

  mux4_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .clrn(clrn), .bus(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i);
    exp_t e;
    e.idx  = 2'(i);
    e.data = dv[i];
    exp_q.push_back(e);
  endtask

  // Scoreboard: every handshake must match the next expected word, in order.
  always @(negedge clk) begin
    if (clrn && bif.y_valid && bif.y_ready) begin
      chk("sb_expected_present", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_sel", 32'(bif.sel), 32'(e.idx));
        chk("sb_y", bif.y, e.data);
        chk("sb_ack", 32'(bif.ack), 32'(4'b0001 << e.idx));
      end
    end
  end

  initial begin
    int ord4 [5];
    int bpw;
    int o1, o2;
`ifdef ARB_FIXED_PRIO_EN
    ord4 = '{0, 1, 0, 1, 0};
    bpw = 0; o1 = 0; o2 = 3;
`else
    ord4 = '{0, 1, 2, 3, 0};
    bpw = 1; o1 = 3; o2 = 0;
`endif
    clrn = 1'b0;
    bif.req = 4'b0000;
    bif.y_ready = 1'b0;
    for (int i = 0; i < 4; i++) dv[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", bif.y, 32'h0);
    chk("rst_y_valid", 32'(bif.y_valid), 32'd0);
    chk("rst_sel", 32'(bif.sel), 32'd0);
    chk("rst_grant", 32'(bif.grant), 32'd0);
    chk("rst_ack", 32'(bif.ack), 32'd0);
    clrn = 1'b1;

    // Single request from requester 2
    dv[2] = 32'h1234_5678;
    bif.req = 4'b0100;
    bif.y_ready = 1'b1;
    push(2);
    cyc();
    chk("single_sel", 32'(bif.sel), 32'd2);
    chk("single_y", bif.y, 32'h1234_5678);
    chk("single_y_valid", 32'(bif.y_valid), 32'd1);
    chk("single_ack", 32'(bif.ack), 32'b0100);
    bif.req = 4'b0000;
    cyc();
    chk("single_idle_valid", 32'(bif.y_valid), 32'd0);
    chk("single_idle_grant", 32'(bif.grant), 32'd0);

    // Asynchronous reset while holding an unconsumed word
    dv[0] = 32'hDEAD_BEEF;
    bif.req = 4'b0001;
    bif.y_ready = 1'b0;
    cyc();
    chk("busy_y", bif.y, 32'hDEAD_BEEF);
    chk("busy_valid", 32'(bif.y_valid), 32'd1);
    #2;
    clrn = 1'b0;
    #1;
    chk("arst_y", bif.y, 32'h0);
    chk("arst_valid", 32'(bif.y_valid), 32'd0);
    chk("arst_grant", 32'(bif.grant), 32'd0);
    chk("arst_sel", 32'(bif.sel), 32'd0);
    chk("arst_ack", 32'(bif.ack), 32'd0);
    bif.req = 4'b0000;
    cyc();
    clrn = 1'b1;

    // All four requesting, consumer always ready
    for (int i = 0; i < 4; i++) dv[i] = 32'hA5A5_0000 + 32'(i * 17 + 3);
    bif.req = 4'b1111;
    bif.y_ready = 1'b1;
    for (int k = 0; k < 5; k++) push(ord4[k]);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("all4_grant", 32'(bif.grant), 32'(4'b0001 << ord4[k]));
      chk("all4_valid", 32'(bif.y_valid), 32'd1);
      if (k == 4) bif.req = 4'b0000;
    end
    cyc();
    chk("all4_idle", 32'(bif.y_valid), 32'd0);

    // Backpressure: word must hold while the consumer stalls
    for (int i = 0; i < 4; i++) dv[i] = 32'h5000_0000 + 32'(i);
    bif.req = 4'b1111;
    bif.y_ready = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("bp_y", bif.y, dv[bpw]);
      chk("bp_sel", 32'(bif.sel), 32'(bpw));
      chk("bp_grant", 32'(bif.grant), 32'(4'b0001 << bpw));
      chk("bp_ack", 32'(bif.ack), 32'd0);
      cyc();
    end
    bif.req = 4'(4'b0001 << bpw);
    bif.y_ready = 1'b1;
    push(bpw);
    #1;
    chk("bp_ack_fire", 32'(bif.ack), 32'(4'b0001 << bpw));
    cyc();
    bif.req = 4'b0000;
    chk("bp_ack_once", 32'(bif.ack), 32'd0);
    chk("bp_idle", 32'(bif.y_valid), 32'd0);
    cyc();
    chk("bp_ack_quiet", 32'(bif.ack), 32'd0);

    // Grant to 3, then 0 and 3 request: 0 goes next
    dv[3] = 32'h3333_0003;
    dv[0] = 32'h0000_C0DE;
    bif.req = 4'b1000;
    push(3);
    cyc();
    chk("fair3_grant", 32'(bif.grant), 32'b1000);
    bif.req = 4'b1001;
    push(0);
    cyc();
    chk("fair0_grant", 32'(bif.grant), 32'b0001);
    bif.req = 4'b0001;
    cyc();
    bif.req = 4'b0000;
    chk("fair_idle", 32'(bif.y_valid), 32'd0);
    cyc();

    // Starting from 1 with 0,1,3 pending
    dv[1] = 32'h1111_0001;
    dv[0] = 32'h0000_0F0F;
    dv[3] = 32'h3030_3030;
    bif.req = 4'b0010;
    push(1);
    cyc();
    chk("ord_first", 32'(bif.grant), 32'b0010);
    bif.req = 4'b1011;
    push(o1);
    push(o2);
    cyc();
    chk("ord_second", 32'(bif.grant), 32'(4'b0001 << o1));
    bif.req = 4'b1001;
    cyc();
    chk("ord_third", 32'(bif.grant), 32'(4'b0001 << o2));
    bif.req = 4'(4'b0001 << o2);
    cyc();
    chk("ord_idle", 32'(bif.y_valid), 32'd0);
    bif.req = 4'b0000;
    repeat (3) cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter and sequencer that shares the 32-bit four-input select path (`mux4x32`) among four requesters. It sits in front of a single downstream consumer, such as the ALU operand or result-bus port. It picks one requester, drives the 2-bit mux select, and registers the selected word into an output holding register. It then completes a valid/ready handshake with the consumer and acknowledges the winning requester.

## Interface
Parameters:
- WIDTH, 32, datapath width of each requester word and of `y`

Ports:
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- req  in  4  request per requester; held high while requester i has a word pending on d_i
- d0  in  WIDTH  requester 0 data; stable while req[0]=1
- d1  in  WIDTH  requester 1 data; stable while req[1]=1
- d2  in  WIDTH  requester 2 data; stable while req[2]=1
- d3  in  WIDTH  requester 3 data; stable while req[3]=1
- y_ready  in  1  consumer accepts `y` this cycle
- y  out  WIDTH  registered selected word
- y_valid  out  1  `y` holds an unconsumed word
- sel  out  2  index of the current grant; equals the mux select `s`
- grant  out  4  one-hot current grant, 0 when idle
- ack  out  4  one-hot, one cycle wide; word from requester i consumed this cycle

## Operation
- States: IDLE (y_valid=0, grant=0) and BUSY (y_valid=1, grant=onehot(sel)).
- Reset (clrn=0, asynchronous):
  - state=IDLE, ptr=0, y=0, y_valid=0, sel=0, grant=0, ack=0.
  - Takes effect immediately, including mid-transfer; a pending word is dropped without ack.
- Arbitration, round-robin:
  - Searches req from index ptr upward, modulo 4.
  - The first set bit wins, giving win index w.
  - On each load, ptr becomes (w+1) mod 4.
- Load action, on a clock edge:
  - sel←w, y←d_w (through the 4:1 select), y_valid←1, state←BUSY.
- IDLE: when any req is set, perform a load; otherwise remain in IDLE.
- BUSY handshake: occurs when y_valid=1 and y_ready=1 in the same cycle.
  - ack[sel]=1 combinationally in that cycle; ack=0 in all other cycles.
- BUSY on handshake:
  - Re-arbitrate with req[sel] masked for that cycle only.
  - If any other req is set, load it and stay in BUSY. This gives back-to-back transfers, one word per cycle.
  - Otherwise go to IDLE and set y_valid←0.
- BUSY without handshake: hold y, sel, grant and ptr unchanged. `y` must not change while y_valid=1 and y_ready=0.
- Requester protocol:
  - Requester i may drop req[i] or change d_i only in the cycle after ack[i].
  - If req[i] is still high after ack[i], that is a new word.
- Dropping req on the granted requester before ack has no effect; the latched word is still delivered.

## Timing
- Request-to-valid latency: req rises at edge n; y_valid=1 after edge n+1 (one cycle).
- Ack occurs in the cycle of the handshake, with no added delay.
- Sustained throughput is 1 word/cycle when two or more requesters alternate and y_ready=1.
- A single continuous requester gets 1 word per 2 cycles, because of the IDLE bubble from masking.
- Worst-case wait for any requester is 3 grants (fairness bound), provided the consumer keeps accepting.

## Configuration
- ARB_FIXED_PRIO_EN defined:
  - Priority is fixed: requester 0 highest, requester 3 lowest.
  - ptr is removed (constant 0).
  - Masking of the just-acked requester still applies.
  - There is no fairness bound.
- ARB_FIXED_PRIO_EN undefined: round-robin arbitration as described in Operation (default build).

## Test plan
- Reset mid-BUSY:
  - Stimulus: drive clrn low with y_valid=1 and y=32'hDEADBEEF.
  - Required: outputs go to zero asynchronously before the next edge; no ack is produced.
- Single request:
  - Stimulus: req=4'b0100, d2=32'h1234_5678, y_ready=1.
  - Required: one cycle later sel=2, y=32'h1234_5678, y_valid=1, ack=4'b0100; next cycle state is IDLE.
- All four requesting after reset, y_ready=1:
  - Required: grant order 0,1,2,3,0 on consecutive cycles, each `y` equal to the matching d_i, and no idle cycles.
- Backpressure:
  - Stimulus: y_ready=0 for 5 cycles while req=4'b1111.
  - Required: y, sel and grant are stable and ack=0; when y_ready rises, ack fires exactly once.
- Fairness after a grant:
  - Stimulus: grant to 3, then req=4'b1001.
  - Required: next grant is 0 under round-robin.
  - Same stimulus with ARB_FIXED_PRIO_EN: the order starting from 1 is 1,0,3 for req=4'b1011.
